// File: rtl/alu_seq_pkg.sv
// Shared constants for the ALU command sequencer: function codes, ALU selects,
// FSM state encoding and the signed-less-than helper.
package alu_seq_pkg;

  localparam int WIDTH     = 32;
  localparam int MUL_ITERS = 32;

  localparam logic [2:0] FUNC_AND = 3'b000;
  localparam logic [2:0] FUNC_OR  = 3'b001;
  localparam logic [2:0] FUNC_ADD = 3'b010;
  localparam logic [2:0] FUNC_SUB = 3'b011;
  localparam logic [2:0] FUNC_SLT = 3'b100;
  localparam logic [2:0] FUNC_MUL = 3'b101;

  localparam logic [1:0] ALU_AND = 2'b00;
  localparam logic [1:0] ALU_OR  = 2'b01;
  localparam logic [1:0] ALU_SUM = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_MUL  = 2'b10,
    ST_RESP = 2'b11
  } state_t;

  // Sign of A-B corrected for two's-complement overflow of the subtraction.
  function automatic logic slt_bit(input logic a_msb, input logic b_msb, input logic diff_msb);
    logic ovf;
    ovf = (a_msb != b_msb) & (diff_msb != a_msb);
    return diff_msb ^ ovf;
  endfunction

endpackage

// File: rtl/alu_seq_decode.sv
// Maps a command function code to the ALU control lines; MUL reports the
// control set used by each shift-add iteration.
module alu_seq_decode
  import alu_seq_pkg::*;
(
  input  logic [2:0] func,
  output logic [1:0] op,
  output logic       binvert,
  output logic       cin,
  output logic       legal
);

  // Combinational function-code decode
  always_comb begin
    op      = ALU_AND;
    binvert = 1'b0;
    cin     = 1'b0;
    legal   = 1'b1;
    case (func)
      FUNC_AND: op = ALU_AND;
      FUNC_OR:  op = ALU_OR;
      FUNC_ADD: op = ALU_SUM;
      FUNC_SUB, FUNC_SLT: begin
        op      = ALU_SUM;
        binvert = 1'b1;
        cin     = 1'b1;
      end
      FUNC_MUL: op = ALU_SUM;
      default:  legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Command-level controller for the shared 32-bit ALU: single-pass ops in one
// ALU cycle, MUL as 32 shift-add iterations through the same adder.
module alu_sequencer
  import alu_seq_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             cmdValid,
  output logic             cmdReady,
  input  logic [2:0]       cmdFunc,
  input  logic [WIDTH-1:0] cmdA,
  input  logic [WIDTH-1:0] cmdB,
  output logic             rspValid,
  input  logic             rspReady,
  output logic [WIDTH-1:0] rspData,
  output logic             rspCarry,
  output logic             rspErr,
  output logic             busy,
  output logic [WIDTH-1:0] aluA,
  output logic [WIDTH-1:0] aluB,
  output logic             aluBinvert,
  output logic             aluCin,
  output logic [1:0]       aluOp,
  input  logic [WIDTH-1:0] aluOut,
  input  logic             aluCout
);

  localparam logic [5:0] MUL_LAST = 6'(MUL_ITERS - 1);

  state_t           state_r, state_s;
  logic [2:0]       func_r, func_s;
  // alu_a_r doubles as the MUL accumulator, alu_b_r as the shifting multiplicand
  logic [WIDTH-1:0] alu_a_r, alu_a_s, alu_b_r, alu_b_s;
  logic [1:0]       alu_op_r, alu_op_s;
  logic             alu_binv_r, alu_binv_s, alu_cin_r, alu_cin_s;
  logic [WIDTH-1:0] mplier_r, mplier_s;
  logic [5:0]       count_r, count_s;
  logic [WIDTH-1:0] rsp_data_r, rsp_data_s;
  logic             rsp_carry_r, rsp_carry_s, rsp_err_r, rsp_err_s;
  logic             rsp_valid_r, rsp_valid_s, cmd_ready_r, cmd_ready_s, busy_r, busy_s;
  logic [WIDTH-1:0] acc_next_s;

  logic [1:0] dec_op_s;
  logic       dec_binv_s, dec_cin_s, dec_legal_s;

  alu_seq_decode u_decode (
    .func    (cmdFunc),
    .op      (dec_op_s),
    .binvert (dec_binv_s),
    .cin     (dec_cin_s),
    .legal   (dec_legal_s)
  );

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_s     = state_r;
    func_s      = func_r;
    alu_a_s     = alu_a_r;
    alu_b_s     = alu_b_r;
    alu_op_s    = alu_op_r;
    alu_binv_s  = alu_binv_r;
    alu_cin_s   = alu_cin_r;
    mplier_s    = mplier_r;
    count_s     = count_r;
    rsp_data_s  = rsp_data_r;
    rsp_carry_s = rsp_carry_r;
    rsp_err_s   = rsp_err_r;
    acc_next_s  = alu_a_r;

    case (state_r)
      ST_IDLE: begin
        if (cmdValid && cmd_ready_r) begin
          func_s = cmdFunc;
          if (!dec_legal_s) begin
            state_s     = ST_RESP;
            rsp_data_s  = {WIDTH{1'b0}};
            rsp_carry_s = 1'b0;
            rsp_err_s   = 1'b1;
          end else if (cmdFunc == FUNC_MUL) begin
            state_s    = ST_MUL;
            alu_a_s    = {WIDTH{1'b0}};
            alu_b_s    = cmdA;
            mplier_s   = cmdB;
            count_s    = 6'd0;
            alu_op_s   = ALU_SUM;
            alu_binv_s = 1'b0;
            alu_cin_s  = 1'b0;
          end else begin
            state_s    = ST_EXEC;
            alu_a_s    = cmdA;
            alu_b_s    = cmdB;
            alu_op_s   = dec_op_s;
            alu_binv_s = dec_binv_s;
            alu_cin_s  = dec_cin_s;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_EXEC: begin
        state_s     = ST_RESP;
        rsp_data_s  = aluOut;
        rsp_carry_s = 1'b0;
        rsp_err_s   = 1'b0;
        case (func_r)
          FUNC_ADD, FUNC_SUB: rsp_carry_s = aluCout;
          FUNC_SLT: rsp_data_s = {31'b0, slt_bit(alu_a_r[WIDTH-1], alu_b_r[WIDTH-1], aluOut[WIDTH-1])};
          default: rsp_carry_s = 1'b0;
        endcase
        alu_a_s    = {WIDTH{1'b0}};
        alu_b_s    = {WIDTH{1'b0}};
        alu_op_s   = ALU_AND;
        alu_binv_s = 1'b0;
        alu_cin_s  = 1'b0;
      end

      ST_MUL: begin
        if (mplier_r[0]) begin
          acc_next_s = aluOut;
        end else begin
          acc_next_s = alu_a_r;
        end
        alu_b_s  = alu_b_r << 1;
        mplier_s = mplier_r >> 1;
        count_s  = count_r + 6'd1;
        if (count_r == MUL_LAST) begin
          state_s     = ST_RESP;
          rsp_data_s  = acc_next_s;
          rsp_carry_s = 1'b0;
          rsp_err_s   = 1'b0;
          alu_a_s     = {WIDTH{1'b0}};
          alu_b_s     = {WIDTH{1'b0}};
          alu_op_s    = ALU_AND;
        end else begin
          alu_a_s = acc_next_s;
        end
      end

      ST_RESP: begin
        if (rspReady) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RESP;
        end
      end

      default: begin
        state_s    = ST_IDLE;
        alu_a_s    = {WIDTH{1'b0}};
        alu_b_s    = {WIDTH{1'b0}};
        alu_op_s   = ALU_AND;
        alu_binv_s = 1'b0;
        alu_cin_s  = 1'b0;
      end
    endcase

    cmd_ready_s = (state_s == ST_IDLE);
    busy_s      = (state_s != ST_IDLE);
    rsp_valid_s = (state_s == ST_RESP);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      func_r      <= 3'b000;
      alu_a_r     <= {WIDTH{1'b0}};
      alu_b_r     <= {WIDTH{1'b0}};
      alu_op_r    <= ALU_AND;
      alu_binv_r  <= 1'b0;
      alu_cin_r   <= 1'b0;
      mplier_r    <= {WIDTH{1'b0}};
      count_r     <= 6'd0;
      rsp_data_r  <= {WIDTH{1'b0}};
      rsp_carry_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_valid_r <= 1'b0;
      cmd_ready_r <= 1'b1;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      func_r      <= func_s;
      alu_a_r     <= alu_a_s;
      alu_b_r     <= alu_b_s;
      alu_op_r    <= alu_op_s;
      alu_binv_r  <= alu_binv_s;
      alu_cin_r   <= alu_cin_s;
      mplier_r    <= mplier_s;
      count_r     <= count_s;
      rsp_data_r  <= rsp_data_s;
      rsp_carry_r <= rsp_carry_s;
      rsp_err_r   <= rsp_err_s;
      rsp_valid_r <= rsp_valid_s;
      cmd_ready_r <= cmd_ready_s;
      busy_r      <= busy_s;
    end
  end

  assign cmdReady   = cmd_ready_r;
  assign busy       = busy_r;
  assign rspValid   = rsp_valid_r;
  assign rspData    = rsp_data_r;
  assign rspCarry   = rsp_carry_r;
  assign rspErr     = rsp_err_r;
  assign aluA       = alu_a_r;
  assign aluB       = alu_b_r;
  assign aluOp      = alu_op_r;
  assign aluBinvert = alu_binv_r;
  assign aluCin     = alu_cin_r;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed vector table, hand-written
// stall/reset sequences and randomized commands against an arithmetic model.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmdValid, cmdReady, rspValid, rspReady, rspCarry, rspErr, busy;
  logic [2:0]  cmdFunc;
  logic [31:0] cmdA, cmdB, rspData, aluA, aluB, aluOut;
  logic        aluBinvert, aluCin, aluCout;
  logic [1:0]  aluOp;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk(clk), .reset(reset),
    .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdFunc(cmdFunc), .cmdA(cmdA), .cmdB(cmdB),
    .rspValid(rspValid), .rspReady(rspReady), .rspData(rspData), .rspCarry(rspCarry), .rspErr(rspErr),
    .busy(busy), .aluA(aluA), .aluB(aluB), .aluBinvert(aluBinvert), .aluCin(aluCin), .aluOp(aluOp),
    .aluOut(aluOut), .aluCout(aluCout)
  );

  // Stand-in for the shared 32-bit ALU: AND/OR/sum with B-invert and carry-in.
  logic [31:0] alu_beff;
  logic [32:0] alu_sum;
  assign alu_beff = aluBinvert ? ~aluB : aluB;
  assign alu_sum  = {1'b0, aluA} + {1'b0, alu_beff} + {32'b0, aluCin};
  assign aluCout  = alu_sum[32];
  always_comb begin
    case (aluOp)
      2'b00:   aluOut = aluA & alu_beff;
      2'b01:   aluOut = aluA | alu_beff;
      default: aluOut = alu_sum[31:0];
    endcase
  end

  typedef struct {
    logic [2:0]  func;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] data;
    logic        carry;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference behaviour from the command semantics, not the sequencing.
  task automatic model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] d, output logic c, output logic e, output int lat);
    logic [32:0] wide;
    logic [63:0] prod;
    d = 32'd0; c = 1'b0; e = 1'b0; lat = 2;
    case (f)
      3'd0: d = a & b;
      3'd1: d = a | b;
      3'd2: begin wide = {1'b0, a} + {1'b0, b}; d = wide[31:0]; c = wide[32]; end
      3'd3: begin d = a - b; c = (a >= b); end
      3'd4: d = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd5: begin prod = {32'd0, a} * {32'd0, b}; d = prod[31:0]; lat = 33; end
      default: begin e = 1'b1; lat = 1; end
    endcase
  endtask

  task automatic run_exp(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ed, input logic ec, input logic ee, input int el,
                         input int stall, input string tag);
    int lat;
    int bad;
    @(negedge clk);
    check({tag, ":cmdReady_idle"}, {31'd0, cmdReady}, 32'd1);
    cmdValid = 1'b1; cmdFunc = f; cmdA = a; cmdB = b;
    rspReady = (stall == 0);
    @(posedge clk); #1;
    cmdValid = 1'b0;
    lat = 1; bad = 0;
    while (!rspValid && lat < 64) begin
      if (cmdReady !== 1'b0 || busy !== 1'b1) bad++;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ":latency"}, 32'(lat), 32'(el));
    check({tag, ":rspData"}, rspData, ed);
    check({tag, ":rspCarry"}, {31'd0, rspCarry}, {31'd0, ec});
    check({tag, ":rspErr"}, {31'd0, rspErr}, {31'd0, ee});
    check({tag, ":busy_cmdReady_during_op"}, 32'(bad), 32'd0);
    if (stall > 0) begin
      bad = 0;
      repeat (stall) begin
        @(posedge clk); #1;
        if (rspValid !== 1'b1 || rspData !== ed || cmdReady !== 1'b0) bad++;
      end
      check({tag, ":stall_hold"}, 32'(bad), 32'd0);
      @(negedge clk);
      rspReady = 1'b1;
    end
    @(posedge clk); #1;
    check({tag, ":idle_after_handshake"}, {30'd0, rspValid, cmdReady}, 32'd1);
  endtask

  task automatic run_cmd(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input int stall, input string tag);
    logic [31:0] ed;
    logic ec, ee;
    int el;
    model(f, a, b, ed, ec, ee, el);
    run_exp(f, a, b, ed, ec, ee, el, stall, tag);
  endtask

  initial begin
    int bad;
    reset = 1'b1; cmdValid = 1'b0; cmdFunc = 3'd0; cmdA = 32'd0; cmdB = 32'd0; rspReady = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset:cmdReady", {31'd0, cmdReady}, 32'd1);
    check("reset:rspValid_busy_err_carry", {28'd0, rspValid, busy, rspErr, rspCarry}, 32'd0);
    check("reset:rspData", rspData, 32'd0);
    check("reset:alu_ctrl", {27'd0, aluOp, aluBinvert, aluCin, 1'b0}, 32'd0);
    check("reset:aluA_or_aluB", aluA | aluB, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    vecs.push_back('{3'd2, 32'd15,         32'd16,         32'd31,         1'b0, 1'b0, 2});
    vecs.push_back('{3'd3, 32'd15,         32'd16,         32'hFFFFFFFF,   1'b0, 1'b0, 2});
    vecs.push_back('{3'd3, 32'd16,         32'd15,         32'd1,          1'b1, 1'b0, 2});
    vecs.push_back('{3'd4, 32'h80000000,   32'd1,          32'd1,          1'b0, 1'b0, 2});
    vecs.push_back('{3'd4, 32'h7FFFFFFF,   32'hFFFFFFFF,   32'd0,          1'b0, 1'b0, 2});
    vecs.push_back('{3'd4, 32'd1,          32'h80000000,   32'd0,          1'b0, 1'b0, 2});
    vecs.push_back('{3'd5, 32'd1234,       32'd5678,       32'd7006652,    1'b0, 1'b0, 33});
    vecs.push_back('{3'd5, 32'h00010000,   32'h00010000,   32'd0,          1'b0, 1'b0, 33});
    vecs.push_back('{3'd5, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          1'b0, 1'b0, 33});
    vecs.push_back('{3'd0, 32'hF0F0F0F0,   32'hFF00FF00,   32'hF000F000,   1'b0, 1'b0, 2});
    vecs.push_back('{3'd1, 32'd1,          32'd3,          32'd3,          1'b0, 1'b0, 2});
    vecs.push_back('{3'd2, 32'hFFFFFFFF,   32'd1,          32'd0,          1'b1, 1'b0, 2});
    vecs.push_back('{3'd7, 32'd5,          32'd6,          32'd0,          1'b0, 1'b1, 1});
    vecs.push_back('{3'd6, 32'hFFFFFFFF,   32'd6,          32'd0,          1'b0, 1'b1, 1});

    for (int i = 0; i < vecs.size(); i++) begin
      run_exp(vecs[i].func, vecs[i].a, vecs[i].b, vecs[i].data, vecs[i].carry,
              vecs[i].err, vecs[i].lat, 0, $sformatf("vec%0d", i));
    end

    // Stalled AND response; a second command offered during the stall must wait.
    @(negedge clk);
    cmdValid = 1'b1; cmdFunc = 3'd0; cmdA = 32'hF0F0F0F0; cmdB = 32'hFF00FF00; rspReady = 1'b0;
    @(posedge clk); #1;
    cmdFunc = 3'd2; cmdA = 32'd2; cmdB = 32'd3;
    repeat (2) @(posedge clk);
    #1;
    check("stall:rspValid", {31'd0, rspValid}, 32'd1);
    bad = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (rspValid !== 1'b1 || rspData !== 32'hF000F000 || cmdReady !== 1'b0) bad++;
    end
    check("stall:held_10_cycles", 32'(bad), 32'd0);
    check("stall:rspData", rspData, 32'hF000F000);
    @(negedge clk);
    rspReady = 1'b1;
    @(posedge clk); #1;
    check("stall:no_bypass_idle", {30'd0, rspValid, cmdReady}, 32'd1);
    @(posedge clk); #1;
    cmdValid = 1'b0;
    check("stall:next_accepted_busy", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    check("stall:next_rspValid", {31'd0, rspValid}, 32'd1);
    check("stall:next_rspData", rspData, 32'd5);
    @(posedge clk); #1;

    // Reset during MUL iteration 10 drops the operation.
    @(negedge clk);
    cmdValid = 1'b1; cmdFunc = 3'd5; cmdA = 32'd1234; cmdB = 32'd5678;
    @(posedge clk); #1;
    cmdValid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midreset:busy_rspValid", {30'd0, busy, rspValid}, 32'd0);
    check("midreset:cmdReady", {31'd0, cmdReady}, 32'd1);
    check("midreset:alu_lines", aluA | aluB | {27'd0, aluOp, aluBinvert, aluCin, 1'b0}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (rspValid !== 1'b0) bad++;
    end
    check("midreset:no_response", 32'(bad), 32'd0);
    run_cmd(3'd1, 32'd1, 32'd3, 0, "midreset_or");

    // Randomized commands with random response back-pressure.
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  f;
      logic [31:0] a, b;
      f = 3'($urandom_range(0, 7));
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 100)) : $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 100)) : $urandom;
      if (i % 7 == 3) b = a;
      run_cmd(f, a, b, $urandom_range(0, 3), $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Command-level controller for the shared 32-bit ALU datapath (AND/OR/add with B-invert and carry-in). Accepts one command at a time over a valid/ready handshake and decodes it into ALU control lines. Single-pass ops take one ALU cycle; MUL is sequenced as 32 shift-add iterations through the same adder. Returns the result over a valid/ready response channel. The ALU is instantiated alongside this block, not inside it.

Parameters:
WIDTH, 32, datapath width; fixed at 32 for this block, present for the package constant only.
MUL_ITERS, 32, shift-add iterations for MUL; must equal WIDTH.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high
cmdValid  input  1  command present
cmdReady  output  1  block can accept a command
cmdFunc  input  3  000 AND, 001 OR, 010 ADD, 011 SUB, 100 SLT, 101 MUL, 110/111 illegal
cmdA  input  32  operand A
cmdB  input  32  operand B
rspValid  output  1  result present
rspReady  input  1  consumer accepts result
rspData  output  32  result
rspCarry  output  1  ALU carry-out for ADD/SUB, else 0
rspErr  output  1  illegal function code
busy  output  1  state != IDLE
aluA  output  32  ALU operand A
aluB  output  32  ALU operand B
aluBinvert  output  1  ALU B-invert
aluCin  output  1  ALU carry-in
aluOp  output  2  ALU select: 00 AND, 01 OR, 10 SUM
aluOut  input  32  ALU result
aluCout  input  1  ALU carry-out

Behaviour:
- Reset values: state IDLE, cmdReady 1, rspValid 0, rspData 0, rspCarry 0, rspErr 0, busy 0, aluA/aluB 0, aluBinvert 0, aluCin 0, aluOp 00, count 0.
- States: IDLE, EXEC, MUL, RESP.
- IDLE: cmdReady = 1. On cmdValid & cmdReady, register func/A/B. Legal non-MUL -> EXEC. MUL -> MUL, with acc=0, mcand=A, mplier=B, count=0. Illegal -> RESP with rspData 0, rspErr 1.
- Decode in EXEC:
  - AND: op 00, binv 0, cin 0.
  - OR: op 01, binv 0, cin 0.
  - ADD: op 10, binv 0, cin 0.
  - SUB and SLT: op 10, binv 1, cin 1.
- EXEC (one cycle): ALU driven combinationally from registered operands. Capture aluOut, then -> RESP.
  - ADD/SUB: rspCarry = aluCout.
  - SLT: rspData = {31'b0, aluOut[31] ^ ovf}, where ovf = (A[31] != B[31]) & (aluOut[31] != A[31]); rspCarry 0.
- MUL (one iteration per cycle):
  - Drive aluA = acc, aluB = mcand, op 10, binv 0, cin 0.
  - If mplier[0], acc <= aluOut; otherwise acc unchanged.
  - mcand <<= 1, mplier >>= 1, count++.
  - When count == MUL_ITERS-1 on the updating cycle, -> RESP with rspData = final acc (low 32 bits of product; overflow discarded), rspCarry 0.
- Outside EXEC/MUL the ALU control lines hold reset values.
- RESP: rspValid = 1 and rspData/rspCarry/rspErr stable until rspValid & rspReady, then -> IDLE. cmdReady = 0 in EXEC, MUL and RESP.
- Latency, accept edge to rspValid high:
  - Single-pass ops: 2 cycles.
  - MUL: 33 cycles.
  - Illegal: 1 cycle.
- Back-to-back: a new command is accepted in the cycle after the response handshake (IDLE). No bypass of response to command in the same cycle.
- rspReady held low: RESP persists indefinitely, outputs frozen.
- Reset mid-operation (any state): next edge forces all reset values. An in-flight result is dropped; no response is produced.
- Wrap-around: ADD/SUB wrap modulo 2^32. MUL wraps modulo 2^32.
- cmdValid in non-IDLE states is ignored; the producer must hold it until accepted.

Decomposition:
- Package alu_seq_pkg: function-code constants (FUNC_AND … FUNC_MUL), ALU select constants (ALU_AND=2'b00, ALU_OR=2'b01, ALU_SUM=2'b10), state encoding, WIDTH.
- One sub-module is natural: alu_seq_decode, a combinational map from func to {aluOp, aluBinvert, aluCin, legal}.
- The FSM, operand registers and MUL iteration stay in alu_sequencer.
- The bench instantiates the existing 32-bit ALU and connects it to the alu* ports.

Test Plan:
- ADD A=15, B=16, rspReady=1 -> rspValid 2 cycles after accept, rspData=31, rspCarry=0, rspErr=0.
- SUB A=15, B=16 -> rspData=0xFFFFFFFF, rspCarry=0. SUB A=16, B=15 -> rspData=1, rspCarry=1.
- SLT A=0x80000000, B=1 -> rspData=1. SLT A=0x7FFFFFFF, B=0xFFFFFFFF -> rspData=0 (overflow correction).
- MUL A=1234, B=5678 -> rspData=7006652 after 33 cycles. MUL A=0x10000, B=0x10000 -> rspData=0. busy high throughout; cmdReady low throughout.
- Hold rspReady=0 for 10 cycles after an AND (A=0xF0F0F0F0, B=0xFF00FF00): rspData stays 0xF000F000, and a cmdValid during the stall is not accepted. Func 111 -> rspErr=1, rspData=0 after 1 cycle.
- Assert reset at MUL iteration 10 -> next cycle: busy=0, rspValid=0, cmdReady=1. A subsequent OR A=1, B=3 returns rspData=3.
